mcu_bus_master: RTL

Initiator (MCU-side) end of the 8-bit parallel MCU↔FPGA register bus. It turns single-beat local read/write commands into the bus handshake on `data`/`address`/`mcu_mstr`/`write_enable`, and completes each beat with the responder's `fpga_ack`. It is used in MCU-less bring-up builds and in the loopback test harness to drive a second FPGA's register file over the real pins. It handles one transaction at a time, with a timeout.

---
 rtl/mcu_bus_master.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mcu_bus_master.sv
// rtl/mcu_bus_master.sv - initiator end of the 8-bit MCU/FPGA register bus
// One beat at a time: setup, strobe, wait for ack, wait for release, respond.
module mcu_bus_master #(
   parameter int SETUP_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       CLK50,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [4:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_timeout,
   output logic       busy,
   inout  wire  [7:0] data,
   output logic [4:0] address,
   output logic       write_enable,
   output logic       mcu_mstr,
   input  logic       fpga_ready,
   input  logic       fpga_ack
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);
   localparam logic [3:0]    SU_LIM = 4'(SETUP_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SETUP    = 3'd1,
      WAIT_ACK = 3'd2,
      WAIT_REL = 3'd3,
      DONE     = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] ack_sync_q, rdy_sync_q;
   logic [3:0]             setup_cnt_q, setup_cnt_d;
   logic [CW-1:0]          to_cnt_q, to_cnt_d, to_cnt_inc;
   logic [4:0]             addr_q, addr_d;
   logic                   we_q, we_d;
   logic [7:0]             wdata_q, wdata_d;
   logic                   drive_q, drive_d;
   logic                   mstr_q, mstr_d;
   logic [7:0]             rdata_q, rdata_d;
   logic                   flag_q, flag_d;
   logic                   ack_s, ready_s;

   assign ack_s   = ack_sync_q[SYNC_STAGES-1];
   assign ready_s = rdy_sync_q[SYNC_STAGES-1];

   always_ff @(posedge CLK50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ack_sync_q  <= '0;
         rdy_sync_q  <= '0;
         setup_cnt_q <= '0;
         to_cnt_q    <= '0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         drive_q     <= 1'b0;
         mstr_q      <= 1'b0;
         rdata_q     <= '0;
         flag_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ack_sync_q  <= {ack_sync_q[SYNC_STAGES-2:0], fpga_ack};
         rdy_sync_q  <= {rdy_sync_q[SYNC_STAGES-2:0], fpga_ready};
         setup_cnt_q <= setup_cnt_d;
         to_cnt_q    <= to_cnt_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         drive_q     <= drive_d;
         mstr_q      <= mstr_d;
         rdata_q     <= rdata_d;
         flag_q      <= flag_d;
      end
   end

   // Saturating increment: a long stall must never wrap back below the limit.
   assign to_cnt_inc = (to_cnt_q == TO_LIM) ? to_cnt_q : to_cnt_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      setup_cnt_d = setup_cnt_q;
      to_cnt_d    = to_cnt_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      drive_d     = drive_q;
      mstr_d      = mstr_q;
      rdata_d     = rdata_q;
      flag_d      = flag_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid && ready_s) begin
               addr_d      = cmd_addr;
               we_d        = cmd_write;
               wdata_d     = cmd_wdata;
               drive_d     = cmd_write;
               setup_cnt_d = '0;
               state_d     = SETUP;
            end
         end
         SETUP: begin
            if (setup_cnt_q == SU_LIM) begin
               mstr_d   = 1'b1;
               to_cnt_d = '0;
               state_d  = WAIT_ACK;
            end else begin
               setup_cnt_d = setup_cnt_q + 4'd1;
            end
         end
         WAIT_ACK: begin
            to_cnt_d = to_cnt_inc;
            // Ack has priority over a timeout landing in the same cycle.
            if (ack_s) begin
               if (!we_q) begin
                  rdata_d = data;
               end
               mstr_d   = 1'b0;
               to_cnt_d = '0;
               state_d  = WAIT_REL;
            end else if (to_cnt_inc == TO_LIM) begin
               flag_d  = 1'b1;
               mstr_d  = 1'b0;
               state_d = WAIT_REL;
            end
         end
         WAIT_REL: begin
            to_cnt_d = to_cnt_inc;
            if (!ack_s) begin
               drive_d = 1'b0;
               state_d = DONE;
            end else if (to_cnt_inc == TO_LIM) begin
               flag_d  = 1'b1;
               drive_d = 1'b0;
               state_d = DONE;
            end
         end
         DONE: begin
            flag_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign cmd_ready    = (state_q == IDLE) && ready_s;
   assign rsp_valid    = (state_q == DONE);
   assign rsp_timeout  = (state_q == DONE) && flag_q;
   assign rsp_rdata    = rdata_q;
   assign busy         = (state_q != IDLE);
   assign address      = addr_q;
   assign write_enable = we_q;
   assign mcu_mstr     = mstr_q;
   assign data         = drive_q ? wdata_q : 8'bzzzz_zzzz;

endmodule
